// File: rtl/r88_int_seq.sv
// Rocket88 interrupt/reset sequencer.
// Prioritises reset > NMI > IRQ. It holds the decoder while it fetches a two-byte
// vector through the memory controller, then presents that vector as the new PC.
// Optional build macro R88_INT_SYNC_EN: when defined, nmiReq and irq pass through
// 2-FF synchronisers before the edge/level logic, which adds two cycles of request latency.
module r88_int_seq #(
  parameter logic [15:0] RESET_VEC   = 16'hFFFC,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC     = 16'hFFFE,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        sysClock,
  input  logic        resetReq,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        instrDone,
  input  logic        memReady,
  input  logic [7:0]  intD,
  output logic        mc_write_full,
  output logic [15:0] mcAddr,
  output logic        readMem,
  output logic        coreHalt,
  output logic        pcLoad,
  output logic [15:0] newPC,
  output logic        irqDisable,
  output logic [1:0]  intCause,
  output logic        busErr
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] CAUSE_RESET = 2'b00;
  localparam logic [1:0] CAUSE_NMI   = 2'b01;
  localparam logic [1:0] CAUSE_IRQ   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    READ_LO,
    ADDR_HI,
    READ_HI,
    LOAD
  } seqState_t;

  seqState_t         state;
  logic              resetPending;
  logic              nmiPending;
  logic              nmiPrev;
  logic [15:0]       vec;
  logic [7:0]        fetchLo;
  logic [WAIT_W-1:0] waitCnt;

  logic              nmiSig;
  logic              irqSig;
  logic              nmiEdge;
  logic              nmiWanted;
  logic              irqEligible;
  logic              acceptNmi;
  logic              acceptIrq;
  logic              accept;
  logic [15:0]       selVec;
  logic [1:0]        selCause;
  logic [15:0]       vecNext;

`ifdef R88_INT_SYNC_EN
  logic [1:0] nmiSync;
  logic [1:0] irqSync;

  // Two-stage synchronisers for the asynchronous request pins
  always_ff @(posedge sysClock or posedge resetReq) begin
    if (resetReq) begin
      nmiSync <= '0;
      irqSync <= '0;
    end else begin
      nmiSync <= {nmiSync[0], nmiReq};
      irqSync <= {irqSync[0], irq};
    end
  end

  // Synchronised request views
  always_comb begin
    nmiSig = nmiSync[1];
    irqSig = irqSync[1];
  end
`else
  // Requests are already synchronous to sysClock
  always_comb begin
    nmiSig = nmiReq;
    irqSig = irq;
  end
`endif

  // Previous NMI level for rising-edge detection
  always_ff @(posedge sysClock or posedge resetReq) begin
    if (resetReq) nmiPrev <= 1'b0;
    else          nmiPrev <= nmiSig;
  end

  // Request qualification and acceptance selection in IDLE
  always_comb begin
    nmiEdge     = nmiSig & ~nmiPrev;
    // A fresh edge counts as a request in the same cycle, so an NMI rising together
    // with an IRQ and instrDone wins over the IRQ.
    nmiWanted   = nmiPending | nmiEdge;
    irqEligible = irqSig & irqEn;
    acceptNmi   = ~resetPending & nmiWanted & instrDone;
    acceptIrq   = ~resetPending & ~nmiWanted & irqEligible & instrDone;
    accept      = resetPending | acceptNmi | acceptIrq;
    selVec      = RESET_VEC;
    selCause    = CAUSE_RESET;
    if (acceptNmi) begin
      selVec   = NMI_VEC;
      selCause = CAUSE_NMI;
    end else if (acceptIrq) begin
      selVec   = IRQ_VEC;
      selCause = CAUSE_IRQ;
    end
    vecNext = vec + 16'd1;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge sysClock or posedge resetReq) begin
    if (resetReq) begin
      state         <= IDLE;
      resetPending  <= 1'b1;
      nmiPending    <= 1'b0;
      vec           <= '0;
      fetchLo       <= '0;
      waitCnt       <= '0;
      mc_write_full <= 1'b0;
      mcAddr        <= '0;
      readMem       <= 1'b0;
      coreHalt      <= 1'b1;
      pcLoad        <= 1'b0;
      newPC         <= '0;
      irqDisable    <= 1'b0;
      intCause      <= CAUSE_RESET;
      busErr        <= 1'b0;
    end else begin
      mc_write_full <= 1'b0;
      pcLoad        <= 1'b0;
      irqDisable    <= 1'b0;
      if (nmiEdge) nmiPending <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            vec           <= selVec;
            intCause      <= selCause;
            mcAddr        <= selVec;
            mc_write_full <= 1'b1;
            coreHalt      <= 1'b1;
            state         <= ADDR_LO;
            // An edge arriving while an already-pending NMI is accepted stays pending
            if (acceptNmi) nmiPending <= nmiPending & nmiEdge;
          end
        end

        ADDR_LO: begin
          readMem <= 1'b1;
          waitCnt <= '0;
          state   <= READ_LO;
        end

        READ_LO: begin
          if (memReady) begin
            fetchLo       <= intD;
            readMem       <= 1'b0;
            mcAddr        <= vecNext;
            mc_write_full <= 1'b1;
            state         <= ADDR_HI;
          end else if (waitCnt == WAIT_LAST) begin
            busErr        <= 1'b1;
            readMem       <= 1'b0;
            mcAddr        <= vec;
            mc_write_full <= 1'b1;
            state         <= ADDR_LO;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        ADDR_HI: begin
          readMem <= 1'b1;
          waitCnt <= '0;
          state   <= READ_HI;
        end

        READ_HI: begin
          if (memReady) begin
            readMem    <= 1'b0;
            newPC      <= {intD, fetchLo};
            pcLoad     <= 1'b1;
            irqDisable <= (intCause != CAUSE_RESET);
            state      <= LOAD;
          end else if (waitCnt == WAIT_LAST) begin
            // A timeout on either byte restarts the whole vector
            busErr        <= 1'b1;
            readMem       <= 1'b0;
            mcAddr        <= vec;
            mc_write_full <= 1'b1;
            state         <= ADDR_LO;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        LOAD: begin
          resetPending <= 1'b0;
          coreHalt     <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r88_int_seq.sv
// Directed bench for r88_int_seq with a small vector-ROM memory model.
module tb_r88_int_seq;

  logic        sysClock;
  logic        resetReq;
  logic        nmiReq;
  logic        irq;
  logic        irqEn;
  logic        instrDone;
  logic        memReady;
  logic [7:0]  intD;
  logic        mc_write_full;
  logic [15:0] mcAddr;
  logic        readMem;
  logic        coreHalt;
  logic        pcLoad;
  logic [15:0] newPC;
  logic        irqDisable;
  logic [1:0]  intCause;
  logic        busErr;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] memAddr  = '0;

  r88_int_seq #(
    .RESET_VEC  (16'hFFFC),
    .NMI_VEC    (16'hFFFA),
    .IRQ_VEC    (16'hFFFE),
    .MEM_TIMEOUT(8)
  ) dut (
    .sysClock     (sysClock),
    .resetReq     (resetReq),
    .nmiReq       (nmiReq),
    .irq          (irq),
    .irqEn        (irqEn),
    .instrDone    (instrDone),
    .memReady     (memReady),
    .intD         (intD),
    .mc_write_full(mc_write_full),
    .mcAddr       (mcAddr),
    .readMem      (readMem),
    .coreHalt     (coreHalt),
    .pcLoad       (pcLoad),
    .newPC        (newPC),
    .irqDisable   (irqDisable),
    .intCause     (intCause),
    .busErr       (busErr)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  // Vector ROM: reset 1234, NMI ABCD, IRQ 5678
  function automatic logic [7:0] memByte(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'hCD;
      16'hFFFB: return 8'hAB;
      16'hFFFC: return 8'h34;
      16'hFFFD: return 8'h12;
      16'hFFFE: return 8'h78;
      16'hFFFF: return 8'h56;
      default:  return 8'h00;
    endcase
  endfunction

  // Memory controller model: address register loaded on mc_write_full
  always @(posedge sysClock) begin
    if (mc_write_full) memAddr <= mcAddr;
  end

  always_comb intD = memByte(memAddr);

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  // Follows one vector fetch starting in ADDR_LO, memReady assumed high
  task automatic expectFetch(input string tag, input logic [15:0] vecLo, input logic [15:0] pc,
                             input logic [1:0] cause, input logic dis);
    logic [15:0] vecHi;
    vecHi = vecLo + 16'd1;
    checkEq({tag, ".addrLoWr"}, 32'(mc_write_full), 32'd1);
    checkEq({tag, ".addrLo"}, 32'(mcAddr), 32'(vecLo));
    checkEq({tag, ".haltLo"}, 32'(coreHalt), 32'd1);
    tick();
    checkEq({tag, ".readLo"}, 32'(readMem), 32'd1);
    tick();
    checkEq({tag, ".addrHiWr"}, 32'(mc_write_full), 32'd1);
    checkEq({tag, ".addrHi"}, 32'(mcAddr), 32'(vecHi));
    tick();
    checkEq({tag, ".readHi"}, 32'(readMem), 32'd1);
    checkEq({tag, ".noLoadYet"}, 32'(pcLoad), 32'd0);
    tick();
    checkEq({tag, ".pcLoad"}, 32'(pcLoad), 32'd1);
    checkEq({tag, ".newPC"}, 32'(newPC), 32'(pc));
    checkEq({tag, ".cause"}, 32'(intCause), 32'(cause));
    checkEq({tag, ".irqDis"}, 32'(irqDisable), 32'(dis));
    checkEq({tag, ".haltLoad"}, 32'(coreHalt), 32'd1);
    tick();
    checkEq({tag, ".pcLoadPulse"}, 32'(pcLoad), 32'd0);
    checkEq({tag, ".run"}, 32'(coreHalt), 32'd0);
    checkEq({tag, ".pcHold"}, 32'(newPC), 32'(pc));
  endtask

  initial begin
    resetReq  = 1'b1;
    nmiReq    = 1'b0;
    irq       = 1'b0;
    irqEn     = 1'b0;
    instrDone = 1'b0;
    memReady  = 1'b1;
    repeat (3) tick();

    // Reset state
    checkEq("rst.halt", 32'(coreHalt), 32'd1);
    checkEq("rst.mcw", 32'(mc_write_full), 32'd0);
    checkEq("rst.read", 32'(readMem), 32'd0);
    checkEq("rst.pcLoad", 32'(pcLoad), 32'd0);
    checkEq("rst.newPC", 32'(newPC), 32'd0);
    checkEq("rst.cause", 32'(intCause), 32'd0);
    checkEq("rst.busErr", 32'(busErr), 32'd0);
    checkEq("rst.mcAddr", 32'(mcAddr), 32'd0);

    // 1: reset fetch, pcLoad after the 5th edge following release
    resetReq = 1'b0;
    tick();
    expectFetch("t1", 16'hFFFC, 16'h1234, 2'b00, 1'b0);

    // 2: IRQ, deasserted mid-sequence without aborting it
    irq = 1'b1; irqEn = 1'b1; instrDone = 1'b1;
    tick();
    instrDone = 1'b0; irq = 1'b0;
    expectFetch("t2", 16'hFFFE, 16'h5678, 2'b10, 1'b1);

    // 3: NMI edge and IRQ together; NMI first, IRQ on next boundary
    irq = 1'b1; nmiReq = 1'b1; instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    expectFetch("t3nmi", 16'hFFFA, 16'hABCD, 2'b01, 1'b1);
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    expectFetch("t3irq", 16'hFFFE, 16'h5678, 2'b10, 1'b1);
    irq = 1'b0; instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    checkEq("t3.noRetrigger", 32'(mc_write_full), 32'd0);
    nmiReq = 1'b0;

    // 4: memReady withheld in READ_LO until timeout, then retry completes
    irq = 1'b1; memReady = 1'b0; instrDone = 1'b1;
    tick();
    instrDone = 1'b0; irq = 1'b0;
    checkEq("t4.addr", 32'(mcAddr), 32'hFFFE);
    tick();
    checkEq("t4.read", 32'(readMem), 32'd1);
    repeat (7) tick();
    checkEq("t4.notYet", 32'(busErr), 32'd0);
    checkEq("t4.stillRead", 32'(readMem), 32'd1);
    tick();
    checkEq("t4.busErr", 32'(busErr), 32'd1);
    checkEq("t4.readDrop", 32'(readMem), 32'd0);
    memReady = 1'b1;
    expectFetch("t4retry", 16'hFFFE, 16'h5678, 2'b10, 1'b1);
    checkEq("t4.sticky", 32'(busErr), 32'd1);

    // 5: resetReq in READ_HI clears asynchronously, then reset fetch restarts
    irq = 1'b1; instrDone = 1'b1;
    tick();
    instrDone = 1'b0; irq = 1'b0;
    repeat (3) tick();
    checkEq("t5.inReadHi", 32'(readMem), 32'd1);
    resetReq = 1'b1;
    #1;
    checkEq("t5.halt", 32'(coreHalt), 32'd1);
    checkEq("t5.read", 32'(readMem), 32'd0);
    checkEq("t5.busErr", 32'(busErr), 32'd0);
    checkEq("t5.newPC", 32'(newPC), 32'd0);
    checkEq("t5.cause", 32'(intCause), 32'd0);
    tick();
    resetReq = 1'b0;
    tick();
    expectFetch("t5", 16'hFFFC, 16'h1234, 2'b00, 1'b0);

    // 6: irq masked by irqEn
    irq = 1'b1; irqEn = 1'b0; instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    checkEq("t6.noAccept", 32'(mc_write_full), 32'd0);
    checkEq("t6.run", 32'(coreHalt), 32'd0);
    repeat (3) tick();
    checkEq("t6.runLater", 32'(coreHalt), 32'd0);

    // 7: NMI edge during an IRQ sequence is served at the next boundary
    irqEn = 1'b1; instrDone = 1'b1;
    tick();
    instrDone = 1'b0; irq = 1'b0; nmiReq = 1'b1;
    expectFetch("t7irq", 16'hFFFE, 16'h5678, 2'b10, 1'b1);
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    expectFetch("t7nmi", 16'hFFFA, 16'hABCD, 2'b01, 1'b1);
    nmiReq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
